// File: rtl/fb_port_arbiter_pkg.sv
// Shared constants for the framebuffer port arbiter: CPU op codes, video
// latency, FSM state encodings and the read-tag record.
package fb_port_arbiter_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int VID_LATENCY = 3;
    // Issue register plus the RAM cycle; the output register supplies the rest.
    localparam int TAG_DEPTH   = VID_LATENCY - 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_CLR      = 3'd4;
    localparam logic [2:0] ST_ACK      = 3'd5;

    typedef struct packed {
        logic valid;
        logic is_vid;
    } rd_tag_t;

endpackage

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: video reads always take the next RAM slot,
// CPU read/write/xor/clear operations fill the remaining slots.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for cpu_req, decodes cpu_op
// RD_ISSUE    | read (read/xor) issued on the first cycle without vid_req
// RD_WAIT     | waiting for the CPU-tagged read data to return
// WR_ISSUE    | write (write/xor) issued on the first cycle without vid_req
// CLR         | zeroes one word per free slot, clr_cnt walks all addresses
// ACK         | one-cycle cpu_ack, cpu_req ignored
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_collision,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] xor_word;
    rd_tag_t           tag_pipe [TAG_DEPTH];

    logic              issue_rd;
    logic              issue_wr;
    logic              vid_rd_ret;
    logic              cpu_rd_ret;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        issue_rd = (state == ST_RD_ISSUE) && !vid_req;
        issue_wr = ((state == ST_WR_ISSUE) || (state == ST_CLR)) && !vid_req;
        wr_addr  = (state == ST_CLR) ? clr_cnt : cpu_addr;
        if (state == ST_CLR) begin
            wr_data = '0;
        end else if (cpu_op == OP_XOR) begin
            wr_data = xor_word;
        end else begin
            wr_data = cpu_wdata;
        end
        vid_rd_ret = tag_pipe[TAG_DEPTH-1].valid &&  tag_pipe[TAG_DEPTH-1].is_vid;
        cpu_rd_ret = tag_pipe[TAG_DEPTH-1].valid && !tag_pipe[TAG_DEPTH-1].is_vid;
    end

    // RAM issue port; video takes precedence over any CPU access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (vid_req) begin
                mem_en      <= 1'b1;
                mem_we      <= 1'b0;
                mem_addr    <= vid_addr;
                tag_pipe[0] <= '{valid: 1'b1, is_vid: 1'b1};
            end else if (issue_rd) begin
                mem_en      <= 1'b1;
                mem_we      <= 1'b0;
                mem_addr    <= cpu_addr;
                tag_pipe[0] <= '{valid: 1'b1, is_vid: 1'b0};
            end else if (issue_wr) begin
                mem_en      <= 1'b1;
                mem_we      <= 1'b1;
                mem_addr    <= wr_addr;
                mem_wdata   <= wr_data;
                tag_pipe[0] <= '0;
            end else begin
                mem_en      <= 1'b0;
                mem_we      <= 1'b0;
                tag_pipe[0] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
        end else begin
            vid_rvalid <= vid_rd_ret;
            if (vid_rd_ret) begin
                vid_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            clr_cnt       <= '0;
            xor_word      <= '0;
            cpu_rdata     <= '0;
            cpu_collision <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        case (cpu_op)
                            OP_READ:  state <= ST_RD_ISSUE;
                            OP_XOR:   state <= ST_RD_ISSUE;
                            OP_WRITE: state <= ST_WR_ISSUE;
                            OP_CLEAR: begin
                                clr_cnt <= '0;
                                state   <= ST_CLR;
                            end
                            default:  state <= ST_IDLE;
                        endcase
                    end
                end
                ST_RD_ISSUE: begin
                    if (!vid_req) begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (cpu_rd_ret) begin
                        cpu_rdata <= mem_rdata;
                        if (cpu_op == OP_XOR) begin
                            xor_word      <= mem_rdata ^ cpu_wdata;
                            cpu_collision <= |(mem_rdata & cpu_wdata);
                            state         <= ST_WR_ISSUE;
                        end else begin
                            cpu_collision <= 1'b0;
                            state         <= ST_ACK;
                        end
                    end
                end
                ST_WR_ISSUE: begin
                    if (!vid_req) begin
                        state <= ST_ACK;
                    end
                end
                ST_CLR: begin
                    if (!vid_req) begin
                        clr_cnt <= clr_cnt + 1'b1;
                        // Last address written: counter wraps to 0 on this edge.
                        if (clr_cnt == '1) begin
                            cpu_rdata     <= '0;
                            cpu_collision <= 1'b0;
                            state         <= ST_ACK;
                        end
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ack = (state == ST_ACK);

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters:
  - the video scanout fetcher, a hard-real-time read stream;
  - the CPU display port, which issues read, write, sprite XOR with collision, and full clear.
- Video always wins a slot and sees a fixed latency.
- CPU operations are sequenced by an FSM that fills the free memory cycles.
- Sits between the video timing/pattern generator and the framebuffer RAM, in the pixel-clock domain.

Parameters:
- ADDR_W, 8, framebuffer word address width (2^ADDR_W words).
- DATA_W, 8, framebuffer word width (pixels per word).

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  one-cycle video read request
- vid_addr  in  ADDR_W  video read address, valid with vid_req
- vid_rvalid  out  1  video read data valid, one-cycle pulse
- vid_rdata  out  DATA_W  video read data
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_op  in  2  00 read, 01 write, 10 xor, 11 clear
- cpu_addr  in  ADDR_W  CPU address (ignored for clear)
- cpu_wdata  in  DATA_W  write/xor data (ignored for read/clear)
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  old word (read/xor); held until next ack
- cpu_collision  out  1  xor only: |(old & cpu_wdata); held until next ack
- mem_en  out  1  RAM access enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read mem_en

Behaviour:
- Reset (async, all outputs):
  - mem_en, mem_we, vid_rvalid, cpu_ack and cpu_collision are 0.
  - mem_addr, mem_wdata, vid_rdata and cpu_rdata are 0.
  - FSM returns to IDLE and the clear counter to 0.
  - In-flight reads are discarded: no vid_rvalid or cpu_ack follows reset.
- Slot rule: at most one RAM access is issued per cycle. A cycle with vid_req=1 reserves the next mem slot for video. The CPU FSM may issue only in a cycle with vid_req=0.
- Video latency: vid_req in cycle t gives mem_en=1, mem_we=0, mem_addr=vid_addr in t+1. vid_rvalid=1 with vid_rdata in t+3. This holds unconditionally, including for back-to-back vid_req.
- Read tagging: a 2-stage tag pipe marks each issued read as VID or CPU. Returning mem_rdata is routed by tag only.
- CPU FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, CLR, ACK.
  - IDLE: on cpu_req, decode cpu_op.
    - read/xor go to RD_ISSUE.
    - write goes to WR_ISSUE.
    - clear goes to CLR with the counter at 0.
  - RD_ISSUE: issues the read when the slot is free, else stalls. Then goes to RD_WAIT.
  - RD_WAIT: on the returning CPU-tagged read, latches cpu_rdata.
    - read: go to ACK.
    - xor: latch new = old ^ cpu_wdata and cpu_collision, then go to WR_ISSUE.
  - WR_ISSUE: issues the write when the slot is free.
    - write: data = cpu_wdata.
    - xor: data = new.
    - Then goes to ACK.
  - CLR: on each free slot, writes 0 to address = counter and increments the counter. After address 2^ADDR_W-1 is written (counter wraps to 0), goes to ACK.
  - ACK: cpu_ack=1 for exactly one cycle, then IDLE. cpu_req is not sampled in ACK, so the next request is accepted one cycle after the ack.
- Write-completion guarantee: a video read issued in the cycle after a CPU write observes the new data.
- Read/write ordering: an XOR's read and write may be separated by any number of video slots. Only video reads interleave, so XOR is atomic with respect to memory contents.
- CPU input stability: cpu_op, cpu_addr and cpu_wdata are held stable while cpu_req=1 until ack. Changing them mid-operation is unsupported; the FSM samples them live.
- Clear result field values: cpu_rdata=0 and cpu_collision=0 at the ack.
- Starvation: if vid_req is continuously high, CPU progress is zero. This is acceptable because the scanout duty cycle is at most 1/8.

Decomposition:
- Shared package: cpu_op encoding constants, VID_LATENCY=3, FSM state enumeration.
- No sub-module; the tag pipe and clear counter stay inline.

Test Plan:
- Video latency: vid_req at addr 0x10 (RAM holds 0xA5), idle CPU -> mem_en at t+1, vid_rvalid with vid_rdata=0xA5 at t+3. Repeat with vid_req on 4 consecutive cycles -> 4 consecutive vid_rvalid pulses in order.
- XOR with collision: RAM[0x20]=0x3C, cpu xor 0x20 with wdata 0x0F -> cpu_rdata=0x3C, cpu_collision=1, RAM[0x20]=0x33. Then xor 0x20 with 0xC0 -> collision=0, RAM[0x20]=0xF3.
- Contention: cpu write 0x05 to 0x40 while vid_req is held high for 6 cycles -> no mem_we during those cycles; write issues on the first free slot. A vid read of 0x40 in the following cycle returns 0x05.
- Clear: cpu clear with vid_req pulsing every 8 cycles -> all 256 words read back 0x00. cpu_ack after exactly 256 writes plus the video-stalled cycles. No video latency deviates from 3.
- Reset mid-op: assert reset_n=0 while in RD_WAIT of an xor -> all outputs 0 immediately. After release, no cpu_ack or vid_rvalid; a fresh read completes normally.
